// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the iterative MUL/DIV divider in EX:
//   - divider FSM state encodings
//   - default operand width
//   - HI/LO write-select constants used by the EX stage when committing
//     divider results (HI <- remainder, LO <- quotient)
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int DIV_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // HI/LO write-select for the EX stage.
  localparam logic [1:0] HILO_WR_NONE = 2'd0;
  localparam logic [1:0] HILO_WR_LO   = 2'd1;
  localparam logic [1:0] HILO_WR_HI   = 2'd2;
  localparam logic [1:0] HILO_WR_BOTH = 2'd3;

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/result bundle between the EX stage (master) and seq_divider (slave).
//   start/sign/dividend/divisor : request, sampled when the divider is idle/done
//   busy                        : high while iterating (pipeline stall)
//   done                        : one-cycle result-valid pulse
//   div_zero/quotient/remainder : results, held until the next accepted start
// -----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, div_zero, quotient, remainder
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, div_zero, quotient, remainder
  );

endinterface

// File: rtl/seq_divider_sub_stage.sv
// -----------------------------------------------------------------------------
// div_sub_stage
// Combinational trial subtractor diff = a - b, built as a ripple of 4-bit
// carry-chain slices computing a + ~b + 1. The operands are zero-extended to
// a multiple of 4 bits, so the final carry-out is 1 exactly when a >= b.
//   a, b   : WIDTH-bit unsigned operands
//   diff   : a - b (low WIDTH bits)
//   borrow : 1 when a < b (the divider's restore decision)
// -----------------------------------------------------------------------------
module div_sub_stage #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NSL = (WIDTH + 3) / 4;
  localparam int PW  = NSL * 4;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_inv;
  logic [PW-1:0] sum_pad;
  logic [NSL:0]  carry;
  logic          pad_unused;

  assign a_pad    = PW'(a);
  assign b_inv    = ~PW'(b);
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NSL; i++) begin : g_slice
    assign {carry[i+1], sum_pad[4*i +: 4]} =
      {1'b0, a_pad[4*i +: 4]} + {1'b0, b_inv[4*i +: 4]} + 5'(carry[i]);
  end

  assign diff       = sum_pad[WIDTH-1:0];
  assign borrow     = ~carry[NSL];
  assign pad_unused = ^sum_pad;

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider: one quotient bit per cycle, result valid
// WIDTH+1 cycles after start is sampled (1 cycle for a zero divisor).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation)
//   dif   : seq_divider_if.slave (start/sign/dividend/divisor in,
//           busy/done/div_zero/quotient/remainder out)
// Build option:
//   SEQ_DIVIDER_SIGNED_EN - when defined, sign=1 performs signed division
//   (magnitudes iterate, quotient negated if operand signs differ, remainder
//   takes the dividend's sign). When undefined, sign is ignored.
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  dif
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out / quotient in
  logic [WIDTH-1:0] d_q, d_d;       // divisor magnitude
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             trial_unused;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic signed [WIDTH-1:0] dvd_s, dvs_s;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg, dvs_neg;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg,
                                                input logic [WIDTH-1:0] x);
    cond_neg = neg ? (~x + WIDTH'(1)) : x;
  endfunction

  assign dvd_s   = dif.dividend;
  assign dvs_s   = dif.divisor;
  assign dvd_neg = dif.sign & (dvd_s < 0);
  assign dvs_neg = dif.sign & (dvs_s < 0);
  assign dvd_mag = cond_neg(dvd_neg, dif.dividend);
  assign dvs_mag = cond_neg(dvs_neg, dif.divisor);
`else
  logic sign_unused;
  assign sign_unused = dif.sign;
  assign dvd_mag     = dif.dividend;
  assign dvs_mag     = dif.divisor;
`endif

  // {R,Q} shifted left by one: the next dividend bit enters R's LSB.
  assign shifted = {r_q, q_q[WIDTH-1]};

  div_sub_stage #(.WIDTH(WIDTH+1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, d_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // On no borrow the difference is below the divisor, so it fits in WIDTH bits;
  // on borrow the shifted value is below the divisor and fits likewise.
  assign r_next       = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next       = {q_q[WIDTH-2:0], ~borrow};
  assign trial_unused = trial[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (dif.start) begin
          dz_d = 1'b0;
          if (dif.divisor == '0) begin
            // Zero divisor: no iteration, results available next cycle.
            state_d = DIV_DONE;
            dz_d    = 1'b1;
            quot_d  = '1;
            rem_d   = dif.dividend;
          end else begin
            state_d = DIV_BUSY;
            r_d     = '0;
            q_d     = dvd_mag;
            d_d     = dvs_mag;
            cnt_d   = CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
`endif
          end
        end else if (state_q == DIV_DONE) begin
          state_d = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
          quot_d = cond_neg(neg_quo_q, q_next);
          rem_d  = cond_neg(neg_rem_q, r_next);
`else
          quot_d = q_next;
          rem_d  = r_next;
`endif
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign dif.busy      = (state_q == DIV_BUSY);
  assign dif.done      = (state_q == DIV_DONE);
  assign dif.div_zero  = dz_q;
  assign dif.quotient  = quot_q;
  assign dif.remainder = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider (WIDTH=32): a table of division vectors plus
// hand-written sequences for reset, busy restart, and back-to-back starts.
// Expected values for signed-mode vectors follow SEQ_DIVIDER_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         sgn;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle and waits (bounded) for done.
  // lat counts negedges after the start edge; timeout returns lat=999.
  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic sgn, output int lat, output logic busy1);
    dif.start    = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    dif.sign     = sgn;
    @(negedge clk);
    dif.start = 1'b0;
    lat   = 1;
    busy1 = dif.busy;
    while (!dif.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!dif.done) lat = 999;
  endtask

  vec_t vecs[16];
  int   nvec;

  initial begin
    int   lat;
    logic b1;
    int   seen;

    dif.start = 1'b0;
    dif.sign = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;

    nvec = 0;
    vecs[nvec++] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
    vecs[nvec++] = '{32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0};
    vecs[nvec++] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0};
    vecs[nvec++] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[nvec++] = '{32'd5, 32'd10, 1'b0, 32'd0, 32'd5, 1'b0};
    vecs[nvec++] = '{32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0};
    vecs[nvec++] = '{32'h80000000, 32'h10, 1'b0, 32'h08000000, 32'd0, 1'b0};
    vecs[nvec++] = '{32'd1000000007, 32'd1000, 1'b0, 32'd1000000, 32'd7, 1'b0};
    vecs[nvec++] = '{32'hDEADBEEF, 32'h00010000, 1'b0, 32'h0000DEAD, 32'h0000BEEF, 1'b0};
    vecs[nvec++] = '{32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[nvec++] = '{32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[nvec++] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[nvec++] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0};
    vecs[nvec++] = '{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 32'd2, 32'hFFFFFFFE, 1'b0};
    vecs[nvec++] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0};
`else
    vecs[nvec++] = '{32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0};
    vecs[nvec++] = '{32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, 32'd7, 1'b0};
    vecs[nvec++] = '{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 32'd0, 32'hFFFFFFF8, 1'b0};
    vecs[nvec++] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000, 1'b0};
`endif
    vecs[nvec++] = '{32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(dif.busy), 0);
    chk("rst_done", W'(dif.done), 0);
    chk("rst_dz", W'(dif.div_zero), 0);
    chk("rst_quot", dif.quotient, 0);
    chk("rst_rem", dif.remainder, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < nvec; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, lat, b1);
      chk($sformatf("v%0d_lat", i), W'(lat), (vecs[i].dvs == 0) ? 32'd1 : 32'd33);
      chk($sformatf("v%0d_busy", i), W'(b1), (vecs[i].dvs == 0) ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_quot", i), dif.quotient, vecs[i].exp_q);
      chk($sformatf("v%0d_rem", i), dif.remainder, vecs[i].exp_r);
      chk($sformatf("v%0d_dz", i), W'(dif.div_zero), W'(vecs[i].exp_dz));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), W'(dif.done), 0);
      chk($sformatf("v%0d_hold_q", i), dif.quotient, vecs[i].exp_q);
    end

    // Start during BUSY is ignored
    dif.start = 1'b1; dif.sign = 1'b0;
    dif.dividend = 32'd200; dif.divisor = 32'd9;
    @(negedge clk);
    dif.start = 1'b0;
    lat = 1;
    seen = 0;
    while (lat < 80) begin
      if (lat == 5) begin
        dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
      end else begin
        dif.start = 1'b0;
      end
      if (dif.done) begin
        seen++;
        if (seen == 1) begin
          chk("restart_lat", W'(lat), 33);
          chk("restart_quot", dif.quotient, 32'd22);
          chk("restart_rem", dif.remainder, 32'd2);
        end
      end
      @(negedge clk);
      lat++;
    end
    chk("restart_done_count", W'(seen), 1);

    // Reset mid-operation: outputs clear asynchronously, no done afterward
    dif.start = 1'b1; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(dif.busy), 0);
    chk("midrst_done", W'(dif.done), 0);
    chk("midrst_quot", dif.quotient, 0);
    chk("midrst_rem", dif.remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (dif.done || dif.busy) seen++;
    end
    chk("midrst_no_done", W'(seen), 0);

    // Back-to-back: zero divide, then start in its DONE cycle, then again
    run_op(32'h12345678, 32'd0, 1'b0, lat, b1);
    chk("b2b_dz_set", W'(dif.div_zero), 1);
    dif.start = 1'b1; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    chk("b2b_dz_cleared", W'(dif.div_zero), 0);
    chk("b2b_busy", W'(dif.busy), 1);
    lat = 1;
    while (!dif.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat1", W'(lat), 33);
    chk("b2b_quot1", dif.quotient, 32'd14);
    dif.start = 1'b1; dif.dividend = 32'hFFFFFFFF; dif.divisor = 32'hFFFFFFFF;
    @(negedge clk);
    dif.start = 1'b0;
    chk("b2b_hold_q", dif.quotient, 32'd14);
    chk("b2b_hold_r", dif.remainder, 32'd2);
    chk("b2b_done_low", W'(dif.done), 0);
    lat = 1;
    while (!dif.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat2", W'(lat), 33);
    chk("b2b_quot2", dif.quotient, 32'd1);
    chk("b2b_rem2", dif.remainder, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
